// File: rtl/tcore_param.sv
// Shared core types for the writeback stage: load metadata, load encodings,
// exception codes and the load-response formatting helper.
package tcore_param;

    localparam int XLEN         = 32;
    localparam int LD_DEPTH_DEF = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [3:0] {
        NO_EXCEPTION      = 4'd0,
        LOAD_ACCESS_FAULT = 4'd5
    } exc_type_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] off;
    } ld_meta_t;

    // Extract and extend the addressed byte/half; undefined encodings give 0.
    function automatic logic [XLEN-1:0] format_load(input logic [2:0]      funct3,
                                                   input logic [1:0]      off,
                                                   input logic [XLEN-1:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        b = raw[{off, 3'b000} +: 8];
        h = off[1] ? raw[31:16] : raw[15:0];
        case (funct3)
            F3_LB:   format_load = {{(XLEN-8){b[7]}}, b};
            F3_LH:   format_load = {{(XLEN-16){h[15]}}, h};
            F3_LW:   format_load = raw;
            F3_LBU:  format_load = {{(XLEN-8){1'b0}}, b};
            F3_LHU:  format_load = {{(XLEN-16){1'b0}}, h};
            default: format_load = '0;
        endcase
    endfunction

endpackage

// File: rtl/stage5_writeback_if.sv
// Boundary of the writeback stage: EX results, load issue/response, decode
// hazard query and the register-file write port.
interface stage5_writeback_if;
    import tcore_param::*;

    logic            ex_valid_i;
    logic            ex_we_i;
    logic [4:0]      ex_rd_i;
    logic [XLEN-1:0] ex_data_i;
    logic            ld_issue_i;
    logic [4:0]      ld_rd_i;
    logic [2:0]      ld_funct3_i;
    logic [1:0]      ld_off_i;
    logic            ld_full_o;
    logic            dmem_valid_i;
    logic            dmem_err_i;
    logic [XLEN-1:0] dmem_rdata_i;
    logic [4:0]      dec_r1_addr_i;
    logic [4:0]      dec_r2_addr_i;
    logic [4:0]      dec_rd_addr_i;
    logic            rf_rw_en_o;
    logic [4:0]      rd_addr_o;
    logic [XLEN-1:0] wb_data_o;
    logic            fwd_a_o;
    logic            fwd_b_o;
    logic            stall_o;
    exc_type_e       exc_type_o;

    modport master (
        output ex_valid_i, ex_we_i, ex_rd_i, ex_data_i,
        output ld_issue_i, ld_rd_i, ld_funct3_i, ld_off_i,
        output dmem_valid_i, dmem_err_i, dmem_rdata_i,
        output dec_r1_addr_i, dec_r2_addr_i, dec_rd_addr_i,
        input  ld_full_o, rf_rw_en_o, rd_addr_o, wb_data_o,
        input  fwd_a_o, fwd_b_o, stall_o, exc_type_o
    );

    modport slave (
        input  ex_valid_i, ex_we_i, ex_rd_i, ex_data_i,
        input  ld_issue_i, ld_rd_i, ld_funct3_i, ld_off_i,
        input  dmem_valid_i, dmem_err_i, dmem_rdata_i,
        input  dec_r1_addr_i, dec_r2_addr_i, dec_rd_addr_i,
        output ld_full_o, rf_rw_en_o, rd_addr_o, wb_data_o,
        output fwd_a_o, fwd_b_o, stall_o, exc_type_o
    );

endinterface

// File: rtl/wb_ld_fifo.sv
// In-order FIFO of outstanding load metadata. push/pop arrive already
// qualified by the caller (no push when full without pop, no pop when empty).
module wb_ld_fifo
    import tcore_param::*;
#(
    parameter int DEPTH = LD_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  ld_meta_t               din,
    output ld_meta_t               dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ld_meta_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // NOTE: storage has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/stage5_writeback.sv
// Writeback stage: arbitrates load responses, a one-entry hold and EX onto the
// register-file port; tracks pending loads for decode. TCORE_WB_BYPASS_EN enables forwarding.
module stage5_writeback
    import tcore_param::*;
#(
    parameter int LD_DEPTH = LD_DEPTH_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    stage5_writeback_if.slave  wb
);

    localparam int CW = $clog2(LD_DEPTH) + 1;

    ld_meta_t        head;
    ld_meta_t        issue_meta;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            pop_ok;
    logic            push_ok;

    logic            hold_valid_q, hold_valid_d;
    logic [4:0]      hold_rd_q, hold_rd_d;
    logic [XLEN-1:0] hold_data_q, hold_data_d;
    logic [31:0]     sb_q, sb_d;

    logic            ex_wr;
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            hazard;
    logic            match_a;
    logic            match_b;

    assign pop_ok     = wb.dmem_valid_i && !fifo_empty;
    assign push_ok    = wb.ld_issue_i && (!fifo_full || pop_ok);
    assign issue_meta = '{rd: wb.ld_rd_i, funct3: wb.ld_funct3_i, off: wb.ld_off_i};

    wb_ld_fifo #(.DEPTH(LD_DEPTH)) u_ld_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push_ok),
        .pop   (pop_ok),
        .din   (issue_meta),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Priority: load response, then the held EX result, then the live EX result.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        ex_wr        = wb.ex_valid_i && wb.ex_we_i && (wb.ex_rd_i != 5'd0);
        if (pop_ok) begin
            if (!wb.dmem_err_i && (head.rd != 5'd0)) begin
                wr_en   = 1'b1;
                wr_addr = head.rd;
                wr_data = format_load(head.funct3, head.off, wb.dmem_rdata_i);
            end
            if (!hold_valid_q && ex_wr) begin
                hold_valid_d = 1'b1;
                hold_rd_d    = wb.ex_rd_i;
                hold_data_d  = wb.ex_data_i;
            end
        end else if (hold_valid_q) begin
            wr_en        = 1'b1;
            wr_addr      = hold_rd_q;
            wr_data      = hold_data_q;
            hold_valid_d = 1'b0;
        end else if (ex_wr) begin
            wr_en   = 1'b1;
            wr_addr = wb.ex_rd_i;
            wr_data = wb.ex_data_i;
        end
    end

    // A new issue overrides a same-cycle clear of the same register.
    always_comb begin
        sb_d = sb_q;
        if (pop_ok)  sb_d[head.rd]    = 1'b0;
        if (push_ok) sb_d[wb.ld_rd_i] = 1'b1;
        sb_d[0] = 1'b0;
    end

    assign hazard  = sb_d[wb.dec_r1_addr_i] | sb_d[wb.dec_r2_addr_i] | sb_d[wb.dec_rd_addr_i];
    assign match_a = wr_en && (wr_addr == wb.dec_r1_addr_i) && (wb.dec_r1_addr_i != 5'd0);
    assign match_b = wr_en && (wr_addr == wb.dec_r2_addr_i) && (wb.dec_r2_addr_i != 5'd0);

`ifdef TCORE_WB_BYPASS_EN
    assign wb.fwd_a_o = match_a;
    assign wb.fwd_b_o = match_b;
    assign wb.stall_o = hold_valid_d | hazard;
`else
    assign wb.fwd_a_o = 1'b0;
    assign wb.fwd_b_o = 1'b0;
    assign wb.stall_o = hold_valid_d | hazard | match_a | match_b;
`endif

    // NOTE: state registers use non-blocking assignments; combinational blocks above use blocking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
            sb_q         <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
            sb_q         <= sb_d;
        end
    end

    assign wb.rf_rw_en_o = wr_en;
    assign wb.rd_addr_o  = wr_addr;
    assign wb.wb_data_o  = wr_data;
    assign wb.ld_full_o  = (fifo_count == CW'(LD_DEPTH));
    assign wb.exc_type_o = (pop_ok && wb.dmem_err_i) ? LOAD_ACCESS_FAULT : NO_EXCEPTION;

    a_issue_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(wb.ld_issue_i && fifo_full && !pop_ok));
    a_resp_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(wb.dmem_valid_i && fifo_empty));
    a_ex_during_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(hold_valid_q && wb.ex_valid_i));

endmodule

// File: tb/tb_stage5_writeback.sv
// Scoreboard bench for stage5_writeback: a queue-based reference model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_stage5_writeback;
    import tcore_param::*;

    typedef struct {
        int rd;
        int f3;
        int off;
    } pend_t;

    typedef struct {
        bit          en;
        int          rd;
        logic [31:0] data;
        bit          fa;
        bit          fb;
        bit          st;
        int          exc;
        bit          full;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    bit   mon_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    pend_t       mq[$];
    exp_t        eq[$];
    bit [31:0]   pend = '0;
    bit          hold_v = 1'b0;
    int          hold_rd = 0;
    logic [31:0] hold_d = '0;

    stage5_writeback_if wbif ();

    stage5_writeback dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .wb     (wbif)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_fmt(int f3, int off, logic [31:0] raw);
        longint unsigned b;
        longint unsigned h;
        longint          v;
        b = (raw >> (off * 8)) & 32'hFF;
        h = (raw >> ((off / 2) * 16)) & 32'hFFFF;
        case (f3)
            0:       v = (b >= 128) ? longint'(b) - 256 : longint'(b);
            1:       v = (h >= 32768) ? longint'(h) - 65536 : longint'(h);
            2:       v = longint'(raw);
            4:       v = longint'(b);
            5:       v = longint'(h);
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    // Predict this cycle's outputs from the current inputs, queue them, advance the model.
    task automatic model_eval();
        exp_t      e;
        pend_t     h;
        bit        resp, ex_wr, issue_ok, hold_n, haz, ma, mb;
        bit [31:0] pn;
        int        r1, r2, rdd;
        e = '{en: 0, rd: 0, data: '0, fa: 0, fb: 0, st: 0, exc: 0, full: 0};
        h = '{rd: 0, f3: 0, off: 0};
        e.full = (mq.size() == LD_DEPTH_DEF);
        resp   = wbif.dmem_valid_i && (mq.size() > 0);
        ex_wr  = wbif.ex_valid_i && wbif.ex_we_i && (wbif.ex_rd_i != 0);
        hold_n = hold_v;
        if (resp) begin
            h = mq[0];
            if (!wbif.dmem_err_i && h.rd != 0) begin
                e.en = 1; e.rd = h.rd; e.data = ref_fmt(h.f3, h.off, wbif.dmem_rdata_i);
            end
            if (wbif.dmem_err_i) e.exc = int'(LOAD_ACCESS_FAULT);
            if (!hold_v && ex_wr) begin
                hold_n = 1; hold_rd = int'(wbif.ex_rd_i); hold_d = wbif.ex_data_i;
            end
        end else if (hold_v) begin
            e.en = 1; e.rd = hold_rd; e.data = hold_d; hold_n = 0;
        end else if (ex_wr) begin
            e.en = 1; e.rd = int'(wbif.ex_rd_i); e.data = wbif.ex_data_i;
        end
        pn = pend;
        if (resp) pn[h.rd] = 1'b0;
        issue_ok = wbif.ld_issue_i && (mq.size() < LD_DEPTH_DEF || resp);
        if (issue_ok && wbif.ld_rd_i != 0) pn[wbif.ld_rd_i] = 1'b1;
        r1  = int'(wbif.dec_r1_addr_i);
        r2  = int'(wbif.dec_r2_addr_i);
        rdd = int'(wbif.dec_rd_addr_i);
        haz = (r1 != 0 && pn[r1]) || (r2 != 0 && pn[r2]) || (rdd != 0 && pn[rdd]);
        ma  = e.en && e.rd == r1 && r1 != 0;
        mb  = e.en && e.rd == r2 && r2 != 0;
`ifdef TCORE_WB_BYPASS_EN
        e.fa = ma; e.fb = mb; e.st = hold_n || haz;
`else
        e.st = hold_n || haz || ma || mb;
`endif
        eq.push_back(e);
        if (resp) void'(mq.pop_front());
        if (issue_ok) mq.push_back('{rd: int'(wbif.ld_rd_i), f3: int'(wbif.ld_funct3_i), off: int'(wbif.ld_off_i)});
        pend   = pn;
        hold_v = hold_n;
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_ni) begin
            if (eq.size() > 0) begin
                exp_t e;
                e = eq.pop_front();
                check("rf_en",  32'(wbif.rf_rw_en_o), 32'(e.en));
                check("rd",     32'(wbif.rd_addr_o),  e.rd);
                check("data",   wbif.wb_data_o,       e.data);
                check("fwd_a",  32'(wbif.fwd_a_o),    32'(e.fa));
                check("fwd_b",  32'(wbif.fwd_b_o),    32'(e.fb));
                check("stall",  32'(wbif.stall_o),    32'(e.st));
                check("exc",    32'(wbif.exc_type_o), e.exc);
                check("ld_full", 32'(wbif.ld_full_o), 32'(e.full));
            end else begin
                check("expect_queue_underflow", 32'(eq.size()), 32'd1);
            end
        end
    end

    task automatic set_idle();
        wbif.ex_valid_i = 0; wbif.ex_we_i = 0; wbif.ex_rd_i = '0; wbif.ex_data_i = '0;
        wbif.ld_issue_i = 0; wbif.ld_rd_i = '0; wbif.ld_funct3_i = '0; wbif.ld_off_i = '0;
        wbif.dmem_valid_i = 0; wbif.dmem_err_i = 0; wbif.dmem_rdata_i = '0;
        wbif.dec_r1_addr_i = '0; wbif.dec_r2_addr_i = '0; wbif.dec_rd_addr_i = '0;
    endtask

    task automatic issue(int rd, int f3, int off);
        wbif.ld_issue_i = 1; wbif.ld_rd_i = 5'(rd); wbif.ld_funct3_i = 3'(f3); wbif.ld_off_i = 2'(off);
    endtask

    task automatic resp(logic [31:0] data, bit err);
        wbif.dmem_valid_i = 1; wbif.dmem_rdata_i = data; wbif.dmem_err_i = err;
    endtask

    task automatic ex(int rd, logic [31:0] data);
        wbif.ex_valid_i = 1; wbif.ex_we_i = 1; wbif.ex_rd_i = 5'(rd); wbif.ex_data_i = data;
    endtask

    task automatic cyc_eval();
        model_eval();
        #2;
    endtask

    task automatic cyc_next();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete(); eq.delete(); pend = '0; hold_v = 0;
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_rf_en"}, 32'(wbif.rf_rw_en_o), 32'd0);
        check({tag, "_rd"},    32'(wbif.rd_addr_o),  32'd0);
        check({tag, "_data"},  wbif.wb_data_o,       32'd0);
        check({tag, "_fwd"},   32'({wbif.fwd_a_o, wbif.fwd_b_o}), 32'd0);
        check({tag, "_stall"}, 32'(wbif.stall_o),    32'd0);
        check({tag, "_exc"},   32'(wbif.exc_type_o), 32'(NO_EXCEPTION));
        check({tag, "_full"},  32'(wbif.ld_full_o),  32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        set_idle();
        repeat (2) @(posedge clk);
        #3;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_ni = 1; mon_en = 1;

        // Byte/half formatting
        set_idle(); issue(5, F3_LB, 3); cyc_eval(); cyc_next();
        set_idle(); resp(32'h80FF_1234, 0); issue(6, F3_LHU, 2); cyc_eval();
        check("lb_en", 32'(wbif.rf_rw_en_o), 32'd1);
        check("lb_rd", 32'(wbif.rd_addr_o), 32'd5);
        check("lb_data", wbif.wb_data_o, 32'hFFFF_FF80);
        cyc_next();
        set_idle(); resp(32'h80FF_1234, 0); cyc_eval();
        check("lhu_rd", 32'(wbif.rd_addr_o), 32'd6);
        check("lhu_data", wbif.wb_data_o, 32'h0000_80FF);
        cyc_next();

        // Load response colliding with EX
        set_idle(); issue(7, F3_LW, 0); cyc_eval(); cyc_next();
        set_idle(); resp(32'h11, 0); ex(8, 32'h22); cyc_eval();
        check("coll_n_rd", 32'(wbif.rd_addr_o), 32'd7);
        check("coll_n_data", wbif.wb_data_o, 32'h11);
        check("coll_n_stall", 32'(wbif.stall_o), 32'd1);
        cyc_next();
        set_idle(); cyc_eval();
        check("coll_n1_en", 32'(wbif.rf_rw_en_o), 32'd1);
        check("coll_n1_rd", 32'(wbif.rd_addr_o), 32'd8);
        check("coll_n1_data", wbif.wb_data_o, 32'h22);
        check("coll_n1_stall", 32'(wbif.stall_o), 32'd0);
        cyc_next();

        // RAW against a pending load
        set_idle(); issue(9, F3_LW, 0); wbif.dec_r1_addr_i = 5'd9; cyc_eval();
        check("sb_issue_stall", 32'(wbif.stall_o), 32'd1);
        cyc_next();
        for (int i = 0; i < 3; i++) begin
            set_idle(); wbif.dec_r1_addr_i = 5'd9; cyc_eval();
            check("sb_wait_stall", 32'(wbif.stall_o), 32'd1);
            cyc_next();
        end
        set_idle(); wbif.dec_r1_addr_i = 5'd9; resp(32'hCAFE_0009, 0); cyc_eval();
`ifdef TCORE_WB_BYPASS_EN
        check("sb_resp_stall", 32'(wbif.stall_o), 32'd0);
        check("sb_resp_fwd_a", 32'(wbif.fwd_a_o), 32'd1);
`else
        check("sb_resp_stall", 32'(wbif.stall_o), 32'd1);
        check("sb_resp_fwd_a", 32'(wbif.fwd_a_o), 32'd0);
`endif
        cyc_next();

        // Metadata FIFO full, simultaneous issue and response
        set_idle(); issue(11, F3_LW, 0); cyc_eval();
        check("full_0", 32'(wbif.ld_full_o), 32'd0);
        cyc_next();
        set_idle(); issue(12, F3_LW, 0); cyc_eval(); cyc_next();
        set_idle(); cyc_eval();
        check("full_1", 32'(wbif.ld_full_o), 32'd1);
        cyc_next();
        set_idle(); issue(13, F3_LW, 0); resp(32'hB, 0); cyc_eval();
        check("full_swap_rd", 32'(wbif.rd_addr_o), 32'd11);
        cyc_next();
        set_idle(); resp(32'hC, 0); cyc_eval();
        check("full_kept", 32'(wbif.ld_full_o), 32'd1);
        check("order_rd12", 32'(wbif.rd_addr_o), 32'd12);
        cyc_next();
        set_idle(); resp(32'hD, 0); cyc_eval();
        check("order_rd13", 32'(wbif.rd_addr_o), 32'd13);
        check("full_drop", 32'(wbif.ld_full_o), 32'd0);
        cyc_next();

        // Faulting response and x0 writes
        set_idle(); issue(10, F3_LW, 0); cyc_eval(); cyc_next();
        set_idle(); resp(32'hDEAD_BEEF, 1); wbif.dec_r1_addr_i = 5'd10; cyc_eval();
        check("err_no_write", 32'(wbif.rf_rw_en_o), 32'd0);
        check("err_exc", 32'(wbif.exc_type_o), 32'(LOAD_ACCESS_FAULT));
        cyc_next();
        set_idle(); wbif.dec_r1_addr_i = 5'd10; cyc_eval();
        check("err_exc_gone", 32'(wbif.exc_type_o), 32'(NO_EXCEPTION));
        check("err_sb_clear", 32'(wbif.stall_o), 32'd0);
        cyc_next();
        set_idle(); ex(0, 32'h55); cyc_eval();
        check("x0_no_write", 32'(wbif.rf_rw_en_o), 32'd0);
        cyc_next();

        // Reset with loads in flight
        set_idle(); issue(1, F3_LW, 0); cyc_eval(); cyc_next();
        set_idle(); issue(2, F3_LW, 0); cyc_eval(); cyc_next();
        mon_en = 0; rst_ni = 0; set_idle();
        wbif.dec_r1_addr_i = 5'd1; wbif.dec_r2_addr_i = 5'd2;
        model_reset();
        #2;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst_ni = 1; mon_en = 1;
        set_idle(); issue(3, F3_LW, 0); wbif.dec_r1_addr_i = 5'd1; cyc_eval();
        check("midrst_sb1_clear", 32'(wbif.stall_o), 32'd0);
        cyc_next();
        set_idle(); resp(32'h3333, 0); cyc_eval();
        check("midrst_next_rd", 32'(wbif.rd_addr_o), 32'd3);
        cyc_next();

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            set_idle();
            if (mq.size() > 0 && $urandom_range(0, 2) == 0)
                resp($urandom(), $urandom_range(0, 7) == 0);
            if ((mq.size() < LD_DEPTH_DEF || wbif.dmem_valid_i) && $urandom_range(0, 1) == 0)
                issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
            if (!hold_v && $urandom_range(0, 1) == 0) begin
                ex($urandom_range(0, 7), $urandom());
                wbif.ex_we_i = ($urandom_range(0, 3) != 0);
            end
            wbif.dec_r1_addr_i = 5'($urandom_range(0, 7));
            wbif.dec_r2_addr_i = 5'($urandom_range(0, 7));
            wbif.dec_rd_addr_i = 5'($urandom_range(0, 7));
            cyc_eval();
            cyc_next();
        end
        for (int i = 0; i < LD_DEPTH_DEF + 2; i++) begin
            set_idle();
            if (mq.size() > 0) resp($urandom(), 0);
            cyc_eval();
            cyc_next();
        end
        check("expect_queue_drained", 32'(eq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
